// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register path.
//   IR_DATA_W / IR_OPC_W : default instruction word and opcode field widths.
//   ir_opcode(word)      : opcode field, taken from the MSBs of a word.
//   ir_operand(word)     : operand field, the bits below the opcode.
// The helpers work on default-width words and are shared with the
// sequencer and the decoder.
package ir_pkg;

  localparam int IR_DATA_W = 16;
  localparam int IR_OPC_W  = 4;

  function automatic logic [IR_OPC_W-1:0] ir_opcode(input logic [IR_DATA_W-1:0] word);
    return word[IR_DATA_W-1 -: IR_OPC_W];
  endfunction

  function automatic logic [IR_DATA_W-IR_OPC_W-1:0] ir_operand(input logic [IR_DATA_W-1:0] word);
    return word[IR_DATA_W-IR_OPC_W-1:0];
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Bundle between the shared bus / control sequencer and the instruction queue.
//   master : the bus and sequencer side; drives bus, ir_write, ir_next, flush
//            and observes the head instruction and the status flags.
//   slave  : the queue itself.
// Handshake: a word is accepted at a rising edge where ir_write = 1 and the
// queue is not full (or a pop is accepted in the same cycle); the head is
// consumed at a rising edge where ir_next = 1 and ir_valid = 1. There is no
// back-pressure wire: a push that cannot be accepted is dropped and
// recorded in the sticky ovf flag. flush overrides both requests.
interface ir_queue_if
  import ir_pkg::*;
#(
  parameter int DATA_W = IR_DATA_W,
  parameter int OPC_W  = IR_OPC_W,
  parameter int DEPTH  = 4
) ();

  logic [DATA_W-1:0]          bus;
  logic                       ir_write;
  logic                       ir_next;
  logic                       flush;
  logic [DATA_W-1:0]          ir_out;
  logic [OPC_W-1:0]           opcode;
  logic [DATA_W-OPC_W-1:0]    operand;
  logic                       ir_valid;
  logic                       full;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       ovf;

  modport master (
    output bus, ir_write, ir_next, flush,
    input  ir_out, opcode, operand, ir_valid, full, count, ovf
  );

  modport slave (
    input  bus, ir_write, ir_next, flush,
    output ir_out, opcode, operand, ir_valid, full, count, ovf
  );

endinterface

// File: rtl/ir_fifo_core.sv
// Storage, pointers and occupancy for the prefetch queue.
//   clk, rst : clock and asynchronous active-low reset.
//   clear    : synchronous discard of every entry; beats push and pop.
//   push     : write request for wr_data.
//   pop      : consume request for the head entry.
//   rd_data  : raw storage at the read pointer (not qualified by empty).
//   count    : occupied entries; full / empty derived from it.
//   pop_ok   : a pop is being accepted this cycle.
// Occupancy is held in count rather than derived from pointers, so the
// pointers are plain $clog2(DEPTH)-bit counters that wrap on their own.
module ir_fifo_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       pop_ok
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop && !empty;
  // A full queue still takes a word when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = storage[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      storage <= '{default: '0};
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        storage[wr_ptr] <= wr_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ir_queue.sv
// Instruction register backed by a DEPTH-entry prefetch FIFO.
//   clk, rst : clock and asynchronous active-low reset.
//   q        : slave side of ir_queue_if -- bus word, push (ir_write),
//              pop (ir_next), flush; head word ir_out split into opcode and
//              operand, ir_valid, full, count and the sticky overflow ovf.
// The head is shown combinationally from registered storage, so a word
// pushed into an empty queue appears the cycle after its push edge.
module ir_queue
  import ir_pkg::*;
#(
  parameter int DATA_W = IR_DATA_W,
  parameter int OPC_W  = IR_OPC_W,
  parameter int DEPTH  = 4
) (
  input logic     clk,
  input logic     rst,
  ir_queue_if.slave q
);

  logic [DATA_W-1:0] head;
  logic              empty;
  logic              pop_ok;
  logic              ovf_r;

  ir_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clear   (q.flush),
    .push    (q.ir_write),
    .pop     (q.ir_next),
    .wr_data (q.bus),
    .rd_data (head),
    .count   (q.count),
    .full    (q.full),
    .empty   (empty),
    .pop_ok  (pop_ok)
  );

  // A push is dropped only when full with no pop freeing a slot; flush
  // clears the flag and also masks any drop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (q.flush) begin
      ovf_r <= 1'b0;
    end else if (q.ir_write && q.full && !pop_ok) begin
      ovf_r <= 1'b1;
    end
  end

  // Stale storage must never leak out, so the head reads 0 when empty.
  assign q.ir_valid = !empty;
  assign q.ir_out   = empty ? '0 : head;
  assign q.opcode   = q.ir_out[DATA_W-1 -: OPC_W];
  assign q.operand  = q.ir_out[DATA_W-OPC_W-1:0];
  assign q.ovf      = ovf_r;

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue with DEPTH = 4, DATA_W = 16, OPC_W = 4.
module tb_ir_queue;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ir_queue_if #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH)) q ();

  ir_queue #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (q.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change 1 ns after a rising edge, outputs are sampled
  // 1 ns after the following rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    q.ir_write = 1'b0;
    q.ir_next  = 1'b0;
    q.flush    = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    q.bus      = w;
    q.ir_write = 1'b1;
    tick();
  endtask

  task automatic pop();
    q.ir_next = 1'b1;
    tick();
  endtask

  task automatic push_pop(input logic [DATA_W-1:0] w);
    q.bus      = w;
    q.ir_write = 1'b1;
    q.ir_next  = 1'b1;
    tick();
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    q.bus      = '0;
    q.ir_write = 1'b0;
    q.ir_next  = 1'b0;
    q.flush    = 1'b0;

    // reset state
    #3;
    check("rst_valid",  32'(q.ir_valid), 32'h0);
    check("rst_out",    32'(q.ir_out),   32'h0);
    check("rst_count",  32'(q.count),    32'h0);
    check("rst_full",   32'(q.full),     32'h0);
    check("rst_ovf",    32'(q.ovf),      32'h0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // single push
    push(16'h3A5C);
    check("one_valid",   32'(q.ir_valid), 32'h1);
    check("one_out",     32'(q.ir_out),   32'h3A5C);
    check("one_opcode",  32'(q.opcode),   32'h3);
    check("one_operand", 32'(q.operand),  32'hA5C);
    check("one_count",   32'(q.count),    32'h1);
    pop();
    check("one_pop_valid", 32'(q.ir_valid), 32'h0);

    // fill to full, then drop a push
    push(16'h1001);
    push(16'h2002);
    push(16'h3003);
    check("fill3_full", 32'(q.full), 32'h0);
    push(16'h4004);
    check("fill_full",  32'(q.full),  32'h1);
    check("fill_count", 32'(q.count), 32'h4);
    check("fill_ovf0",  32'(q.ovf),   32'h0);
    push(16'h5005);
    check("drop_ovf",   32'(q.ovf),    32'h1);
    check("drop_count", 32'(q.count),  32'h4);
    check("drop_head",  32'(q.ir_out), 32'h1001);

    // drain across the pointer wrap
    pop();
    check("drain1", 32'(q.ir_out), 32'h2002);
    pop();
    check("drain2", 32'(q.ir_out), 32'h3003);
    pop();
    check("drain3", 32'(q.ir_out), 32'h4004);
    pop();
    check("drain4_valid", 32'(q.ir_valid), 32'h0);
    check("drain4_out",   32'(q.ir_out),   32'h0);
    pop();
    check("empty_pop_count", 32'(q.count), 32'h0);
    check("ovf_sticky",      32'(q.ovf),   32'h1);
    push(16'h6006);
    check("wrap_head",  32'(q.ir_out), 32'h6006);
    check("wrap_count", 32'(q.count),  32'h1);

    // simultaneous push and pop while full
    push(16'h9009);
    push(16'hA00A);
    push(16'hB00B);
    check("refill_full", 32'(q.full), 32'h1);
    push_pop(16'h7007);
    check("pp_count", 32'(q.count),  32'h4);
    check("pp_ovf",   32'(q.ovf),    32'h1);
    check("pp_head",  32'(q.ir_out), 32'h9009);
    pop();
    check("pp_drain1", 32'(q.ir_out), 32'hA00A);
    pop();
    check("pp_drain2", 32'(q.ir_out), 32'hB00B);
    pop();
    check("pp_drain3", 32'(q.ir_out), 32'h7007);
    check("pp_count1", 32'(q.count),  32'h1);

    // flush beats push and pop
    push(16'hC00C);
    push(16'hD00D);
    check("pre_flush_count", 32'(q.count), 32'h3);
    q.bus      = 16'h8008;
    q.ir_write = 1'b1;
    q.ir_next  = 1'b1;
    q.flush    = 1'b1;
    tick();
    check("flush_count", 32'(q.count),    32'h0);
    check("flush_valid", 32'(q.ir_valid), 32'h0);
    check("flush_ovf",   32'(q.ovf),      32'h0);
    check("flush_out",   32'(q.ir_out),   32'h0);
    push(16'hE00E);
    check("post_flush_head",  32'(q.ir_out), 32'hE00E);
    check("post_flush_count", 32'(q.count),  32'h1);

    // asynchronous reset between edges
    push(16'hF00F);
    check("pre_rst_count", 32'(q.count), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(q.ir_valid), 32'h0);
    check("arst_count", 32'(q.count),    32'h0);
    check("arst_out",   32'(q.ir_out),   32'h0);
    rst = 1'b1;
    tick();
    push(16'h1234);
    check("post_rst_head",  32'(q.ir_out), 32'h1234);
    check("post_rst_count", 32'(q.count),  32'h1);
    check("post_rst_op",    32'(q.opcode), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the single-word instruction register: an instruction register backed by a DEPTH-entry prefetch FIFO.
- Captures instruction words from the shared bus ahead of execution.
- Presents the head instruction already split into opcode and operand fields.
- Supports synchronous flush (branch/jump) and flags dropped writes.
- Sits between the bus and the control sequencer.

Parameters:
- DATA_W, 16, instruction/bus word width.
- OPC_W, 4, opcode field width, taken from the MSBs; must be < DATA_W.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst = 0.
- bus  in  DATA_W  shared bus, sampled on push.
- ir_write  in  1  push request.
- ir_next  in  1  pop request: sequencer consumes the head.
- flush  in  1  synchronous discard of all entries.
- ir_out  out  DATA_W  head instruction word.
- opcode  out  OPC_W  ir_out[DATA_W-1 -: OPC_W].
- operand  out  DATA_W-OPC_W  ir_out[DATA_W-OPC_W-1:0].
- ir_valid  out  1  queue non-empty.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- ovf  out  1  sticky: a push was dropped.

Behaviour:
- Reset (rst = 0, async):
  - Read and write pointers = 0, count = 0, ovf = 0.
  - ir_out, opcode and operand read 0; ir_valid = 0; full = 0.
  - Storage contents need not be cleared.
- Output decode:
  - ir_out = storage[rd_ptr] when ir_valid = 1, else 0. Combinational from registered storage and pointers; no extra stage.
  - opcode and operand are pure slices of ir_out.
- Push, evaluated at the rising edge:
  - Accepted when ir_write = 1 and (full = 0 or a pop is accepted in the same cycle).
  - bus is written to storage[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop:
  - Accepted when ir_next = 1 and ir_valid = 1; rd_ptr increments modulo DEPTH.
  - ir_next while empty is ignored: no pointer change, no error.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on push+pop in the same cycle, including when full.
- Latency:
  - A word pushed into an empty queue appears on ir_out / ir_valid the cycle after the push edge.
  - No same-cycle bypass from bus to ir_out.
- Full with push and no pop: the push is dropped and ovf is set to 1 at that edge. ovf stays set until flush or reset.
- Flush:
  - Has highest priority. At the edge: pointers = 0, count = 0, ovf = 0.
  - Any push or pop in the same cycle is discarded.
  - The cycle after, ir_valid = 0 and ir_out = 0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by count, not by pointer comparison.
- Reset mid-operation: asynchronous clear as above, regardless of pending ir_write, ir_next or flush.
- Implementation rules: no latches; all state in a single always block sensitive to posedge clk / negedge rst.

Decomposition:
- Shared package ir_pkg holds:
  - Default constants IR_DATA_W = 16 and IR_OPC_W = 4.
  - Functions ir_opcode(word) and ir_operand(word), reused by the sequencer and decoder.
- One natural sub-module, ir_fifo_core:
  - Contains storage array, pointers, count, full and empty logic, parametrised by DATA_W and DEPTH.
  - ir_queue wraps it and adds field split, zeroing of ir_out when empty, ovf and flush priority.

Test Plan:
- Reset then single push:
  - Stimulus: rst low 10 ns then high; bus = 16'h3A5C, ir_write for 1 cycle.
  - Response: next cycle ir_valid = 1, ir_out = 16'h3A5C, opcode = 4'h3, operand = 12'hA5C, count = 1.
- Fill to full (DEPTH = 4):
  - Stimulus: push 16'h1001, 16'h2002, 16'h3003, 16'h4004, then push 16'h5005.
  - Response: full = 1 and count = 4 after the 4th push; after the 5th, ovf = 1, count stays 4, ir_out = 16'h1001.
- Drain with wrap:
  - Stimulus: from full, assert ir_next 4 cycles.
  - Response: ir_out steps 16'h2002, 16'h3003, 16'h4004, then ir_valid = 0 with ir_out = 0. An extra ir_next leaves count = 0.
  - Then push 16'h6006: ir_out = 16'h6006, proving pointer wrap.
- Simultaneous push and pop:
  - Stimulus: while full, push 16'h7007 and pop in the same cycle.
  - Response: count stays 4, ovf unchanged, head advances. 16'h7007 emerges after the three older entries.
- Flush priority:
  - Stimulus: with count = 3 and ovf = 1, assert flush together with ir_write (16'h8008) and ir_next.
  - Response: next cycle count = 0, ir_valid = 0, ovf = 0, ir_out = 0. 16'h8008 is not stored.
- Async reset mid-stream:
  - Stimulus: drop rst low between clock edges with count = 2.
  - Response: ir_valid, count and ir_out go to 0 immediately, without waiting for a clock edge. Pushes after release behave as from empty.
